// File: rtl/amo_rmw_engine_pkg.sv
// Shared definitions for the AMO read-modify-write engine.
//   - AMO command codes as carried on req_cmd
//   - FSM state encoding
//   - is_legal_amo(): command legality check; LR/SC (cmd 6/7) are legal only
//     when the build defines AMO_LRSC_EN
package amo_rmw_engine_pkg;

    localparam logic [4:0] CMD_SWAP = 5'h04;
    localparam logic [4:0] CMD_LR   = 5'h06;
    localparam logic [4:0] CMD_SC   = 5'h07;
    localparam logic [4:0] CMD_ADD  = 5'h08;
    localparam logic [4:0] CMD_XOR  = 5'h09;
    localparam logic [4:0] CMD_OR   = 5'h0a;
    localparam logic [4:0] CMD_AND  = 5'h0b;
    localparam logic [4:0] CMD_MIN  = 5'h0c;
    localparam logic [4:0] CMD_MAX  = 5'h0d;
    localparam logic [4:0] CMD_MINU = 5'h0e;
    localparam logic [4:0] CMD_MAXU = 5'h0f;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    function automatic logic is_legal_amo(input logic [4:0] cmd);
        logic legal_s;
        case (cmd)
            CMD_SWAP, CMD_ADD, CMD_XOR, CMD_OR, CMD_AND,
            CMD_MIN, CMD_MAX, CMD_MINU, CMD_MAXU: legal_s = 1'b1;
`ifdef AMO_LRSC_EN
            CMD_LR, CMD_SC:                       legal_s = 1'b1;
`endif
            default:                              legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/amo_rmw_engine_if.sv
// Bus bundle of the AMO engine: core request/response channel plus the
// data-memory read and write channels.
//   slave  modport: the engine side (accepts requests, drives memory traffic)
//   master modport: the environment side (core issuing AMOs + memory)
interface amo_rmw_engine_if #(
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [3:0]        req_mask;
    logic [TAG_W-1:0]  req_tag;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_resp_valid;
    logic [31:0]       rd_resp_data;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_mask;
    logic              wr_ack;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_err;

    modport slave (
        input  req_valid, req_cmd, req_addr, req_data, req_mask, req_tag,
        output req_ready,
        output rd_valid, rd_addr,
        input  rd_ready, rd_resp_valid, rd_resp_data,
        output wr_valid, wr_addr, wr_data, wr_mask,
        input  wr_ready, wr_ack,
        output resp_valid, resp_data, resp_tag, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_cmd, req_addr, req_data, req_mask, req_tag,
        input  req_ready,
        input  rd_valid, rd_addr,
        output rd_ready, rd_resp_valid, rd_resp_data,
        input  wr_valid, wr_addr, wr_data, wr_mask,
        output wr_ready, wr_ack,
        input  resp_valid, resp_data, resp_tag, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/amo_rmw_engine_alu.sv
// AMOALU: combinational AMO compute plus byte merge.
// Ports:
//   cmd  - AMO command code
//   lhs  - old memory word
//   rhs  - request operand
//   mask - byte write mask
//   out  - merged word: masked bytes from the op result, others from lhs
module amo_rmw_engine_alu
    import amo_rmw_engine_pkg::*;
(
    input  logic [4:0]  cmd,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic [3:0]  mask,
    output logic [31:0] out
);
    logic [31:0] res_s;
    logic [31:0] byte_en_s;

    // Full-word operation result
    always_comb begin
        res_s = lhs;
        case (cmd)
            CMD_SWAP: res_s = rhs;
            CMD_ADD:  res_s = lhs + rhs;
            CMD_XOR:  res_s = lhs ^ rhs;
            CMD_OR:   res_s = lhs | rhs;
            CMD_AND:  res_s = lhs & rhs;
            CMD_MIN:  res_s = ($signed(lhs) < $signed(rhs)) ? lhs : rhs;
            CMD_MAX:  res_s = ($signed(lhs) > $signed(rhs)) ? lhs : rhs;
            CMD_MINU: res_s = (lhs < rhs) ? lhs : rhs;
            CMD_MAXU: res_s = (lhs > rhs) ? lhs : rhs;
            default:  res_s = lhs;
        endcase
    end

    // Byte merge against the old word
    always_comb begin
        byte_en_s = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        out       = (res_s & byte_en_s) | (lhs & ~byte_en_s);
    end
endmodule

// File: rtl/amo_rmw_engine.sv
// AMO read-modify-write engine (initiator side of the atomic path).
// One AMO at a time: read the word, compute through the AMOALU, write the
// merged word back, then return the old word to the core.
// Ports:
//   clock, reset - system clock, asynchronous active-high reset
//   bus          - amo_rmw_engine_if.slave: req_*, rd_*, wr_*, resp_*
// Optional build macro AMO_LRSC_EN adds LR (6) / SC (7) with a single
// reservation register; without it those commands take the error path.
module amo_rmw_engine
    import amo_rmw_engine_pkg::*;
#(
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    amo_rmw_engine_if.slave bus
);
    state_e            state_r;
    logic [4:0]        cmd_r;
    logic [31:0]       data_r;
    logic [3:0]        mask_r;
    logic [31:0]       old_r;
    logic              req_ready_r;
    logic              rd_valid_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              wr_valid_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [31:0]       wr_data_r;
    logic [3:0]        wr_mask_r;
    logic              resp_valid_r;
    logic [31:0]       resp_data_r;
    logic [TAG_W-1:0]  resp_tag_r;
    logic              resp_err_r;
    logic [31:0]       alu_out_s;
`ifdef AMO_LRSC_EN
    logic              resv_valid_r;
    logic [ADDR_W-3:0] resv_addr_r;
`endif

    amo_rmw_engine_alu u_alu (
        .cmd  (cmd_r),
        .lhs  (bus.rd_resp_data),
        .rhs  (data_r),
        .mask (mask_r),
        .out  (alu_out_s)
    );

    assign bus.req_ready  = req_ready_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd_addr    = rd_addr_r;
    assign bus.wr_valid   = wr_valid_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.wr_mask    = wr_mask_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_tag   = resp_tag_r;
    assign bus.resp_err   = resp_err_r;

    // Engine FSM with registered bus outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cmd_r        <= 5'h00;
            data_r       <= 32'h0;
            mask_r       <= 4'h0;
            old_r        <= 32'h0;
            // Raised on the first clock after reset is released
            req_ready_r  <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_addr_r    <= '0;
            wr_valid_r   <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= 32'h0;
            wr_mask_r    <= 4'h0;
            resp_valid_r <= 1'b0;
            resp_data_r  <= 32'h0;
            resp_tag_r   <= '0;
            resp_err_r   <= 1'b0;
`ifdef AMO_LRSC_EN
            resv_valid_r <= 1'b0;
            resv_addr_r  <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_ready_r && bus.req_valid) begin
                        req_ready_r <= 1'b0;
                        cmd_r       <= bus.req_cmd;
                        data_r      <= bus.req_data;
                        mask_r      <= bus.req_mask;
                        rd_addr_r   <= bus.req_addr;
                        wr_addr_r   <= bus.req_addr;
                        wr_mask_r   <= bus.req_mask;
                        resp_tag_r  <= bus.req_tag;
                        if (!is_legal_amo(bus.req_cmd) || (bus.req_addr[1:0] != 2'b00)) begin
                            // No memory traffic for a rejected request
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_data_r  <= 32'h0;
                            state_r      <= ST_RESP;
                        end
`ifdef AMO_LRSC_EN
                        else if (bus.req_cmd == CMD_SC) begin
                            resv_valid_r <= 1'b0;
                            if (resv_valid_r && (resv_addr_r == bus.req_addr[ADDR_W-1:2])) begin
                                // SC writes the operand directly; no read needed
                                wr_data_r  <= bus.req_data;
                                wr_valid_r <= 1'b1;
                                state_r    <= ST_WR_REQ;
                            end else begin
                                resp_valid_r <= 1'b1;
                                resp_err_r   <= 1'b0;
                                resp_data_r  <= 32'h1;
                                state_r      <= ST_RESP;
                            end
                        end
`endif
                        else begin
                            rd_valid_r <= 1'b1;
                            state_r    <= ST_RD_REQ;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_RD_REQ: begin
                    if (bus.rd_ready) begin
                        rd_valid_r <= 1'b0;
                        state_r    <= ST_RD_WAIT;
                    end else begin
                        rd_valid_r <= 1'b1;
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.rd_resp_valid) begin
                        old_r <= bus.rd_resp_data;
`ifdef AMO_LRSC_EN
                        if (cmd_r == CMD_LR) begin
                            resv_valid_r <= 1'b1;
                            resv_addr_r  <= rd_addr_r[ADDR_W-1:2];
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_data_r  <= bus.rd_resp_data;
                            state_r      <= ST_RESP;
                        end else begin
                            // An AMO store to the reserved word kills the reservation
                            if (resv_addr_r == rd_addr_r[ADDR_W-1:2]) begin
                                resv_valid_r <= 1'b0;
                            end else begin
                                resv_valid_r <= resv_valid_r;
                            end
                            wr_data_r  <= alu_out_s;
                            wr_valid_r <= 1'b1;
                            state_r    <= ST_WR_REQ;
                        end
`else
                        wr_data_r  <= alu_out_s;
                        wr_valid_r <= 1'b1;
                        state_r    <= ST_WR_REQ;
`endif
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_WR_REQ: begin
                    if (bus.wr_ready) begin
                        wr_valid_r <= 1'b0;
                        state_r    <= ST_WR_WAIT;
                    end else begin
                        wr_valid_r <= 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (bus.wr_ack) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
`ifdef AMO_LRSC_EN
                        resp_data_r  <= (cmd_r == CMD_SC) ? 32'h0 : old_r;
`else
                        resp_data_r  <= old_r;
`endif
                        state_r      <= ST_RESP;
                    end else begin
                        state_r <= ST_WR_WAIT;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        resp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    rd_valid_r   <= 1'b0;
                    wr_valid_r   <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    req_ready_r  <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/amo_rmw_engine.md
Name: amo_rmw_engine

Overview:
Initiator side of the atomic path. Accepts one AMO request at a time from the core and performs a read of the target word over the memory port. It computes the new value through the existing AMOALU, writes it back, and returns the old value to the core. Sits between the core's AMO issue logic and the data-memory port.

Parameters:
TAG_W, 4, width of the request/response tag
ADDR_W, 32, byte-address width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  AMO request valid
req_ready  out  1  engine idle, request accepted when valid&ready
req_cmd  in  5  4=SWAP, 8=ADD, 9=XOR, a=OR, b=AND, c=MIN, d=MAX, e=MINU, f=MAXU
req_addr  in  ADDR_W  byte address, word aligned
req_data  in  32  rhs operand
req_mask  in  4  byte write mask
req_tag  in  TAG_W  returned unchanged
rd_valid  out  1  memory read request
rd_ready  in  1  memory accepts read
rd_addr  out  ADDR_W  read address
rd_resp_valid  in  1  read data valid
rd_resp_data  in  32  old memory word
wr_valid  out  1  memory write request
wr_ready  in  1  memory accepts write
wr_addr  out  ADDR_W  write address
wr_data  out  32  merged new word
wr_mask  out  4  byte mask
wr_ack  in  1  write complete
resp_valid  out  1  response valid, held until resp_ready
resp_ready  in  1  core accepts response
resp_data  out  32  old memory word (SC: 0 success / 1 fail)
resp_tag  out  TAG_W  tag of request
resp_err  out  1  unsupported cmd or misaligned addr

Behaviour:
- Reset (async, active-high): state IDLE. rd_valid, wr_valid, resp_valid, resp_err = 0. Data/addr/tag registers = 0. req_ready = 1 after reset deasserts.
- States:
  - IDLE -> RD_REQ on accept. The accept cycle latches cmd/addr/data/mask/tag.
  - RD_REQ: rd_valid=1 until rd_ready.
  - RD_WAIT: on rd_resp_valid, latch old word and register the AMOALU output (lhs=old, rhs=latched data, mask) -> WR_REQ.
  - WR_REQ: wr_valid=1 until wr_ready.
  - WR_WAIT: on wr_ack -> RESP.
  - RESP: resp_valid=1 until resp_ready -> IDLE.
- req_ready = (state==IDLE). No request pipelining; one outstanding op.
- Error path: if cmd is not in {4,8..f} or addr[1:0]!=0 -> RESP directly with resp_err=1, resp_data=0, and no memory traffic.
- rd_resp_valid or wr_ack arriving in any other state is ignored.
- Same-cycle rd_valid&rd_ready&rd_resp_valid is not legal. The memory responds at least 1 cycle after acceptance.
- wr_data = bytes with mask=1 from the ALU result, mask=0 bytes from the old word. wr_mask = latched mask.
- MIN/MAX signed, MINU/MAXU unsigned, ADD wraps mod 2^32.
- Minimum latency accept -> resp_valid: 4 cycles, with zero-wait memory (rd_ready/wr_ready same cycle, resp/ack next cycle).
- resp_* held stable while resp_valid & !resp_ready.
- Reset asserted mid-operation aborts immediately. An outstanding memory read/write is abandoned, and the memory side must tolerate this.

Optional Feature:
AMO_LRSC_EN
- Defined:
  - cmd 6=LR and cmd 7=SC become legal. Adds a reservation register (valid + word address).
  - LR: read only (RD_REQ -> RD_WAIT -> RESP), returns the word, sets reservation to addr.
  - SC: if reservation valid and address matches, do WR_REQ/WR_WAIT with req_data and return resp_data=0. Otherwise skip the write and return 1.
  - Any SC clears the reservation. Any AMO write to the reserved address clears it. Reset clears it.
- Undefined: cmds 6/7 take the error path; no reservation logic.

Decomposition:
- Shared package holds:
  - command code constants (SWAP, ADD, XOR, OR, AND, MIN, MAX, MINU, MAXU, LR, SC);
  - state encoding localparams (IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP);
  - an is_legal_amo(cmd) function.
- One sub-module: instance of the existing AMOALU for the combinational compute. The FSM lives in amo_rmw_engine.

Test Plan:
- ADD at 0x100: mem=0x0000_0005, data=0x0000_0003, mask=f -> wr_data=0x0000_0008, resp_data=0x0000_0005, tag echoed, 4-cycle latency with zero-wait memory.
- MIN vs MINU: mem=0xFFFF_FFFF, data=0x1 -> MIN writes 0xFFFF_FFFF, MINU writes 0x0000_0001. Both return 0xFFFF_FFFF.
- Masked SWAP: mem=0x1122_3344, data=0xAABB_CCDD, mask=0x3 -> wr_data=0x1122_CCDD, wr_mask=0x3.
- Errors: addr=0x102 or cmd=0x1 -> resp_err=1, resp_data=0, no rd_valid/wr_valid.
- Backpressure: rd_ready low 3 cycles, wr_ready low 2, resp_ready low 5 -> valids/addresses stay stable, req_ready=0 throughout; reset pulse in WR_WAIT -> all outputs 0 asynchronously, req_ready=1 after release.
- AMO_LRSC_EN: LR 0x200, SC 0x200 data=0x7 -> write occurs, resp=0. A second SC 0x200 -> no write, resp=1. LR 0x200 then SC 0x204 -> resp=1.
